// File: rtl/uart_tx_scheduler_if.sv
// Byte-stream request bundle between the four requesters and the shared UART transmitter.
interface uart_tx_scheduler_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;

  modport master (output req_valid, output req_data, output req_last, input req_ready);
  modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/uart_tx_scheduler.sv
// 8N1 UART transmitter shared by four byte-stream requesters with round-robin
// arbitration and an optional per-requester packet lock.
module uart_tx_scheduler #(
  parameter int BAUD_RATE     = 9600,
  parameter int CLOCK_FREQ_HZ = 12000000
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_scheduler_if.slave  bus,
  output logic                TX,
  output logic                busy,
  output logic [1:0]          grant_id,
  output logic                locked
);
  localparam int BIT_PERIOD = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic [1:0]       r_grant, r_last_grant, r_lock_owner;
  logic             r_locked;

  logic             w_bit_end, w_found, w_xfer;
  logic [1:0]       w_sel, w_idx;
  logic [3:0]       w_ready;

  assign w_bit_end = (r_cycle_cnt == CNT_MAX);

  // While locked only the owner is eligible; an idle owner stalls the line.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_lock_owner;
    w_idx   = '0;
    if (r_locked) begin
      w_found = bus.req_valid[r_lock_owner];
    end else begin
      for (int unsigned k = 1; k <= 4; k++) begin
        w_idx = r_last_grant + 2'(k);
        if (!w_found && bus.req_valid[w_idx]) begin
          w_found = 1'b1;
          w_sel   = w_idx;
        end
      end
    end
  end

  assign w_xfer        = (r_state == IDLE) && w_found && !rst;
  assign w_ready       = w_xfer ? (4'b0001 << w_sel) : '0;
  assign bus.req_ready = w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    case (r_state)
      IDLE:  if (w_xfer) w_next = START;
      START: if (w_bit_end) w_next = DATA;
      DATA:  if (w_bit_end && r_bit_cnt == 3'd7) w_next = STOP;
      STOP:  if (w_bit_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt  <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_tx         <= 1'b1;
      r_grant      <= 2'd0;
      r_last_grant <= 2'd3;
      r_lock_owner <= 2'd0;
      r_locked     <= 1'b0;
    end else begin
      if (r_state != IDLE) r_cycle_cnt <= w_bit_end ? '0 : r_cycle_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          r_cycle_cnt <= '0;
          if (w_xfer) begin
            r_shift      <= bus.req_data[{w_sel, 3'b000} +: 8];
            r_tx         <= 1'b0;
            r_bit_cnt    <= '0;
            r_grant      <= w_sel;
            r_last_grant <= w_sel;
            r_lock_owner <= w_sel;
            r_locked     <= !bus.req_last[w_sel];
          end
        end
        START: if (w_bit_end) r_tx <= r_shift[0];
        DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == 3'd7) begin
              r_tx <= 1'b1;
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        STOP: r_tx <= 1'b1;
        default: r_tx <= 1'b1;
      endcase
    end
  end

  assign TX       = r_tx;
  assign grant_id = r_grant;
  assign locked   = r_locked;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler at 10 clocks per bit.
module tb_uart_tx_scheduler;
  logic       clk;
  logic       rst;
  logic       TX;
  logic       busy;
  logic [1:0] grant_id;
  logic       locked;
  int         n_tests;
  int         n_fail;
  int         cyc;
  int         prev_start;
  logic [7:0] fb [4];

  uart_tx_scheduler_if u_if ();

  uart_tx_scheduler #(
    .BAUD_RATE     (100),
    .CLOCK_FREQ_HZ (1000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (u_if),
    .TX       (TX),
    .busy     (busy),
    .grant_id (grant_id),
    .locked   (locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Called in the first start-bit cycle; returns in the first IDLE cycle after the frame.
  task automatic frame(input string tag, input logic [7:0] b);
    logic exp_bit, bit_ok, busy_ok, rdy_ok;
    busy_ok = 1'b1;
    rdy_ok  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      exp_bit = 1'b0;
      else if (k == 9) exp_bit = 1'b1;
      else             exp_bit = b[k-1];
      bit_ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
        if (TX !== exp_bit) bit_ok = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (u_if.req_ready !== 4'b0000) rdy_ok = 1'b0;
        tick(1);
      end
      check($sformatf("%s bit%0d", tag, k), 32'(bit_ok), 1);
    end
    check($sformatf("%s busy_during", tag), 32'(busy_ok), 1);
    check($sformatf("%s ready_zero", tag), 32'(rdy_ok), 1);
    check($sformatf("%s busy_end", tag), 32'(busy), 0);
    check($sformatf("%s tx_idle", tag), 32'(TX), 1);
  endtask

  initial begin
    logic ok_busy, ok_rdy;
    n_tests = 0;
    n_fail  = 0;
    prev_start = 0;
    fb[0] = 8'hA5; fb[1] = 8'h3C; fb[2] = 8'hF0; fb[3] = 8'h0F;

    // Reset state, with all requesters valid to confirm ready is gated
    rst = 1'b1;
    u_if.req_valid = 4'hF;
    u_if.req_data  = '0;
    u_if.req_last  = 4'hF;
    tick(2);
    check("rst tx", 32'(TX), 1);
    check("rst busy", 32'(busy), 0);
    check("rst ready", 32'(u_if.req_ready), 0);
    check("rst grant", 32'(grant_id), 0);
    check("rst locked", 32'(locked), 0);

    // Single byte 0x31 from requester 0
    u_if.req_valid = 4'b0001;
    u_if.req_data  = 32'h0000_0031;
    u_if.req_last  = 4'b0001;
    rst = 1'b0;
    #1;
    check("single ready", 32'(u_if.req_ready), 1);
    tick(1);
    check("single busy_rise", 32'(busy), 1);
    check("single grant", 32'(grant_id), 0);
    check("single locked", 32'(locked), 0);
    check("single ready_busy", 32'(u_if.req_ready), 0);
    u_if.req_valid = 4'b0000;
    frame("single", 8'h31);

    // Fairness: all four valid continuously
    do_reset();
    u_if.req_valid = 4'hF;
    u_if.req_last  = 4'hF;
    u_if.req_data  = {fb[3], fb[2], fb[1], fb[0]};
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr%0d ready", i), 32'(u_if.req_ready), 1 << (i % 4));
      tick(1);
      check($sformatf("rr%0d busy", i), 32'(busy), 1);
      check($sformatf("rr%0d grant", i), 32'(grant_id), i % 4);
      if (i > 0) check($sformatf("rr%0d spacing", i), cyc - prev_start, 101);
      prev_start = cyc;
      frame($sformatf("rr%0d", i), fb[i % 4]);
    end
    u_if.req_valid = 4'b0000;

    // Packet lock: requester 1 sends 0x41,0x42,0x43 while requester 2 waits
    do_reset();
    u_if.req_valid = 4'b0110;
    u_if.req_data  = 32'h0055_4100;
    u_if.req_last  = 4'b0100;
    #1;
    check("lock0 ready", 32'(u_if.req_ready), 2);
    tick(1);
    check("lock0 grant", 32'(grant_id), 1);
    check("lock0 locked", 32'(locked), 1);
    u_if.req_data = 32'h0055_4200;
    frame("lock0", 8'h41);
    check("lock1 ready", 32'(u_if.req_ready), 2);
    tick(1);
    check("lock1 grant", 32'(grant_id), 1);
    check("lock1 locked", 32'(locked), 1);
    u_if.req_data = 32'h0055_4300;
    u_if.req_last = 4'b0110;
    frame("lock1", 8'h42);
    check("lock2 ready", 32'(u_if.req_ready), 2);
    tick(1);
    check("lock2 grant", 32'(grant_id), 1);
    check("lock2 locked", 32'(locked), 0);
    u_if.req_valid = 4'b0100;
    frame("lock2", 8'h43);
    check("lock3 ready", 32'(u_if.req_ready), 4);
    tick(1);
    check("lock3 grant", 32'(grant_id), 2);
    check("lock3 locked", 32'(locked), 0);
    u_if.req_valid = 4'b0000;
    frame("lock3", 8'h55);

    // Lock stall: owner 3 goes quiet mid-packet while requester 0 is valid
    do_reset();
    u_if.req_valid = 4'b1000;
    u_if.req_data  = 32'h3300_000F;
    u_if.req_last  = 4'b0001;
    #1;
    check("stall first ready", 32'(u_if.req_ready), 8);
    tick(1);
    check("stall first grant", 32'(grant_id), 3);
    check("stall first locked", 32'(locked), 1);
    u_if.req_valid = 4'b0001;
    frame("stall first", 8'h33);
    ok_busy = 1'b1;
    ok_rdy  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (busy !== 1'b0) ok_busy = 1'b0;
      if (u_if.req_ready !== 4'b0000) ok_rdy = 1'b0;
      tick(1);
    end
    check("stall idle", 32'(ok_busy), 1);
    check("stall no_ready", 32'(ok_rdy), 1);
    check("stall locked", 32'(locked), 1);
    check("stall grant", 32'(grant_id), 3);
    u_if.req_valid = 4'b1001;
    u_if.req_data  = 32'h3400_000F;
    u_if.req_last  = 4'b1001;
    #1;
    check("stall resume ready", 32'(u_if.req_ready), 8);
    tick(1);
    check("stall resume grant", 32'(grant_id), 3);
    check("stall resume locked", 32'(locked), 0);
    u_if.req_valid = 4'b0001;
    frame("stall resume", 8'h34);
    check("stall req0 ready", 32'(u_if.req_ready), 1);
    tick(1);
    check("stall req0 grant", 32'(grant_id), 0);

    // Reset in the middle of data bit 4 of 0x0F (a zero bit)
    tick(55);
    check("midrst tx_before", 32'(TX), 0);
    check("midrst busy_before", 32'(busy), 1);
    u_if.req_valid = 4'b1001;
    rst = 1'b1;
    #1;
    check("midrst tx", 32'(TX), 1);
    check("midrst busy", 32'(busy), 0);
    check("midrst ready", 32'(u_if.req_ready), 0);
    check("midrst grant", 32'(grant_id), 0);
    tick(1);
    rst = 1'b0;
    #1;
    check("midrst rr ready", 32'(u_if.req_ready), 1);
    tick(1);
    check("midrst rr grant", 32'(grant_id), 0);
    check("midrst rr busy", 32'(busy), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
